// File: rtl/triangle_setup.sv
`default_nettype none
// ============================================================================
// Module   : triangle_setup
// Purpose  : Triangle setup stage ahead of the rasterizer. Accepts one
//            triangle at a time, computes twice its signed screen area,
//            discards degenerate triangles (and, when enabled, back-facing
//            ones) and produces the reciprocal area in fixed point through a
//            bit-serial restoring divider.
// Config   : TRI_SETUP_BACKFACE_CULL_EN - when defined, triangles with a
//            negative area_x2 are discarded and counted like zero-area ones.
// Ports    : axi_aclk / axi_aresetn  clock, async active-low reset
//            in_valid / in_ready     upstream triangle handshake
//            in_xy [50:0]            {v3y,v3x,v2y,v2x,v1y,v1x}, x 9b, y 8b
//            in_attr [55:0]          {z3,z2,z1,color}, passed through
//            out_valid / out_ready   rasterizer handshake
//            out_xy / out_attr       registered copy of the accepted triangle
//            out_inv_area [31:0]     floor(2^FRAC_BITS / |area_x2|)
//            busy                    high whenever not idle
//            drop_count              saturating count of discarded triangles
// Revision : 1.0 - initial release
// ============================================================================
module triangle_setup #(
  parameter int FRAC_BITS  = 24,
  parameter int DROP_CNT_W = 16
) (
  input  logic                  axi_aclk,
  input  logic                  axi_aresetn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [50:0]           in_xy,
  input  logic [55:0]           in_attr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [50:0]           out_xy,
  output logic [55:0]           out_attr,
  output logic [31:0]           out_inv_area,
  output logic                  busy,
  output logic [DROP_CNT_W-1:0] drop_count
);

  // Quotient holds 2^FRAC_BITS exactly when |area_x2| == 1, hence one extra bit.
  localparam int C_QUO_W = FRAC_BITS + 1;
  localparam int C_CNT_W = $clog2(C_QUO_W);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AREA = 2'd1,
    S_DIV  = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t                r_state;
  logic                  r_in_ready;
  logic                  r_busy;
  logic                  r_out_valid;
  logic [50:0]           r_xy;
  logic [55:0]           r_attr;
  logic [31:0]           r_inv;
  logic [DROP_CNT_W-1:0] r_drop;
  logic [20:0]           r_div;   // |area_x2|
  logic [20:0]           r_rem;   // partial remainder, always < r_div
  logic [C_QUO_W-1:0]    r_dvd;   // dividend bits shift out the top, quotient bits in the bottom
  logic [C_CNT_W-1:0]    r_cnt;

  // --------------------------------------------------------------------------
  // Twice the signed area. Operands are widened to 21 bits before the
  // multiply so every partial product is formed at full result width.
  // --------------------------------------------------------------------------
  logic signed [20:0] w_x1, w_y1, w_x2, w_y2, w_x3, w_y3;
  logic signed [20:0] w_area;
  logic        [20:0] w_abs;
  logic               w_drop;

  assign w_x1 = {12'd0, r_xy[8:0]};
  assign w_y1 = {13'd0, r_xy[16:9]};
  assign w_x2 = {12'd0, r_xy[25:17]};
  assign w_y2 = {13'd0, r_xy[33:26]};
  assign w_x3 = {12'd0, r_xy[42:34]};
  assign w_y3 = {13'd0, r_xy[50:43]};

  assign w_area = w_x1 * (w_y2 - w_y3)
                + w_x2 * (w_y3 - w_y1)
                + w_x3 * (w_y1 - w_y2);

  assign w_abs = w_area[20] ? -w_area : w_area;

`ifdef TRI_SETUP_BACKFACE_CULL_EN
  assign w_drop = (w_area == 21'sd0) || w_area[20];
`else
  assign w_drop = (w_area == 21'sd0);
`endif

  // --------------------------------------------------------------------------
  // One restoring-division step: bring down the next dividend bit, subtract
  // the divisor when it fits. The difference is below r_div, so 21 bits hold it.
  // --------------------------------------------------------------------------
  logic [21:0] w_rem_sh;
  logic        w_ge;
  logic [20:0] w_rem_nx;

  assign w_rem_sh = {r_rem, r_dvd[C_QUO_W-1]};
  assign w_ge     = (w_rem_sh >= {1'b0, r_div});
  assign w_rem_nx = w_ge ? 21'(w_rem_sh - {1'b0, r_div}) : w_rem_sh[20:0];

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b0;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_xy        <= '0;
      r_attr      <= '0;
      r_inv       <= '0;
      r_drop      <= '0;
      r_div       <= '0;
      r_rem       <= '0;
      r_dvd       <= '0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_xy       <= in_xy;
            r_attr     <= in_attr;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_AREA;
          end else begin
            // Also the first edge after reset release.
            r_in_ready <= 1'b1;
          end
        end

        S_AREA: begin
          if (w_drop) begin
            if (r_drop != {DROP_CNT_W{1'b1}}) begin
              r_drop <= r_drop + DROP_CNT_W'(1);
            end
            r_in_ready <= 1'b1;
            r_busy     <= 1'b0;
            r_state    <= S_IDLE;
          end else begin
            r_div   <= w_abs;
            r_rem   <= '0;
            r_dvd   <= {1'b1, {FRAC_BITS{1'b0}}};
            r_cnt   <= '0;
            r_state <= S_DIV;
          end
        end

        S_DIV: begin
          r_rem <= w_rem_nx;
          r_dvd <= {r_dvd[C_QUO_W-2:0], w_ge};
          r_cnt <= r_cnt + C_CNT_W'(1);
          if (r_cnt == C_CNT_W'(FRAC_BITS)) begin
            r_inv       <= 32'({r_dvd[C_QUO_W-2:0], w_ge});
            r_out_valid <= 1'b1;
            r_state     <= S_OUT;
          end
        end

        S_OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready     = r_in_ready;
  assign busy         = r_busy;
  assign out_valid    = r_out_valid;
  assign out_xy       = r_xy;
  assign out_attr     = r_attr;
  assign out_inv_area = r_inv;
  assign drop_count   = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_triangle_setup.sv
`default_nettype none
// ============================================================================
// Module   : tb_triangle_setup
// Purpose  : Self-checking bench for triangle_setup. A reference model derives
//            each triangle's fate directly from its vertices (integer area,
//            integer division); a negedge monitor compares every output
//            transfer, stall stability, handshake timing and drop count.
// Revision : 1.0 - initial release
// ============================================================================
module tb_triangle_setup;

  logic        axi_aclk    = 1'b0;
  logic        axi_aresetn = 1'b0;
  logic        in_valid    = 1'b0;
  logic        in_ready;
  logic [50:0] in_xy       = '0;
  logic [55:0] in_attr     = '0;
  logic        out_valid;
  logic        out_ready   = 1'b0;
  logic [50:0] out_xy;
  logic [55:0] out_attr;
  logic [31:0] out_inv_area;
  logic        busy;
  logic [15:0] drop_count;

  triangle_setup #(.FRAC_BITS(24), .DROP_CNT_W(16)) dut (
    .axi_aclk     (axi_aclk),
    .axi_aresetn  (axi_aresetn),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_xy        (in_xy),
    .in_attr      (in_attr),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_xy       (out_xy),
    .out_attr     (out_attr),
    .out_inv_area (out_inv_area),
    .busy         (busy),
    .drop_count   (drop_count)
  );

  always #5 axi_aclk = ~axi_aclk;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int rdy_mode = 0;   // 0: always ready, 1: random, 2: driven by main sequence

  always @(posedge axi_aclk) cyc++;

  always @(posedge axi_aclk) begin
    #1;
    if (rdy_mode == 0)      out_ready = 1'b1;
    else if (rdy_mode == 1) out_ready = ($urandom % 3) != 0;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [50:0] pack(input int x1, input int y1, input int x2,
                                       input int y2, input int x3, input int y3);
    return {y3[7:0], x3[8:0], y2[7:0], x2[8:0], y1[7:0], x1[8:0]};
  endfunction

  // Reference: what the stage must do with a triangle, from its vertices.
  function automatic void model(input logic [50:0] xy, output bit drop, output logic [31:0] inv);
    longint x1 = xy[8:0];
    longint y1 = xy[16:9];
    longint x2 = xy[25:17];
    longint y2 = xy[33:26];
    longint x3 = xy[42:34];
    longint y3 = xy[50:43];
    longint one = 1;
    longint a;
    a = x1 * (y2 - y3) + x2 * (y3 - y1) + x3 * (y1 - y2);
    drop = (a == 0);
`ifdef TRI_SETUP_BACKFACE_CULL_EN
    if (a < 0) drop = 1'b1;
`endif
    if (a < 0) a = -a;
    inv = drop ? 32'd0 : 32'((one << 24) / a);
  endfunction

  function automatic logic [31:0] model_inv(input logic [50:0] xy);
    bit d;
    logic [31:0] v;
    model(xy, d, v);
    return v;
  endfunction

  typedef struct {
    logic [50:0] xy;
    logic [55:0] attr;
    logic [31:0] inv;
    int          acc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] got_inv[$];
  logic [55:0] got_attr[$];
  int          n_pop       = 0;
  int          model_drops = 0;
  logic [31:0] last_inv    = '0;
  logic [55:0] last_attr   = '0;
  int          last_lat    = 0;

  // Monitor state
  bit          stall     = 1'b0;
  logic [50:0] s_xy;
  logic [55:0] s_attr;
  logic [31:0] s_inv;
  bit          prev_ov   = 1'b0;
  bit          hs_pend   = 1'b0;
  int          hs_edge   = 0;
  bit          drop_pend = 1'b0;
  int          drop_edge = 0;

  always @(negedge axi_aclk) begin
    if (!axi_aresetn) begin
      exp_q.delete();
      model_drops = 0;
      stall       = 1'b0;
      prev_ov     = 1'b0;
      hs_pend     = 1'b0;
      drop_pend   = 1'b0;
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_in_ready", 64'(in_ready), 64'(0));
      chk("rst_drop_count", 64'(drop_count), 64'(0));
    end else begin
      if (stall) begin
        chk("stall_out_valid", 64'(out_valid), 64'(1));
        chk("stall_out_xy", 64'(out_xy), 64'(s_xy));
        chk("stall_out_attr", 64'(out_attr), 64'(s_attr));
        chk("stall_out_inv", 64'(out_inv_area), 64'(s_inv));
      end
      if (hs_pend && cyc == hs_edge) begin
        chk("in_ready_after_transfer", 64'(in_ready), 64'(1));
        hs_pend = 1'b0;
      end
      if (drop_pend && cyc == drop_edge + 1) begin
        chk("in_ready_after_drop", 64'(in_ready), 64'(1));
        drop_pend = 1'b0;
      end
      if (in_ready) begin
        chk("idle_busy", 64'(busy), 64'(0));
        chk("idle_drop_count", 64'(drop_count), 64'(model_drops));
      end
      if (out_valid) begin
        chk("out_in_ready_low", 64'(in_ready), 64'(0));
        chk("out_busy", 64'(busy), 64'(1));
        if (!prev_ov && exp_q.size() > 0) begin
          last_lat = cyc - exp_q[0].acc;
          chk("out_latency", 64'(last_lat), 64'(26));
        end
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", 64'(out_valid), 64'(0));
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("out_xy", 64'(out_xy), 64'(e.xy));
          chk("out_attr", 64'(out_attr), 64'(e.attr));
          chk("out_inv_area", 64'(out_inv_area), 64'(e.inv));
        end
        n_pop++;
        last_inv  = out_inv_area;
        last_attr = out_attr;
        got_inv.push_back(out_inv_area);
        got_attr.push_back(out_attr);
        hs_pend = 1'b1;
        hs_edge = cyc + 1;
      end
      stall   = out_valid && !out_ready;
      s_xy    = out_xy;
      s_attr  = out_attr;
      s_inv   = out_inv_area;
      prev_ov = out_valid;
      if (in_valid && in_ready) begin
        bit          d;
        logic [31:0] v;
        model(in_xy, d, v);
        if (d) begin
          model_drops++;
          drop_pend = 1'b1;
          drop_edge = cyc + 1;
        end else begin
          exp_t e;
          e.xy   = in_xy;
          e.attr = in_attr;
          e.inv  = v;
          e.acc  = cyc + 1;
          exp_q.push_back(e);
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic [50:0] xy, input logic [55:0] attr);
    int n;
    in_xy    = xy;
    in_attr  = attr;
    in_valid = 1'b1;
    for (n = 0; n < 2000; n++) begin
      @(negedge axi_aclk);
      if (in_ready) break;
    end
    if (n == 2000) chk("send_timeout", 64'(in_ready), 64'(1));
    @(posedge axi_aclk);
    #1;
    in_valid = 1'b0;
    in_xy    = {$urandom, $urandom};
    in_attr  = {$urandom, $urandom};
  endtask

  task automatic drain();
    int n;
    for (n = 0; n < 4000; n++) begin
      @(negedge axi_aclk);
      if (exp_q.size() == 0 && in_ready) break;
    end
    if (n == 4000) chk("drain_timeout", 64'(exp_q.size()), 64'(0));
    @(posedge axi_aclk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (checks=%0d)", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [50:0] t;
    int          n0;
    int          n;
    rdy_mode = 0;
    repeat (2) @(posedge axi_aclk);
    #1;
    chk("reset_in_ready", 64'(in_ready), 64'(0));
    chk("reset_out_valid", 64'(out_valid), 64'(0));
    chk("reset_out_inv", 64'(out_inv_area), 64'(0));
    chk("reset_out_xy", 64'(out_xy), 64'(0));
    chk("reset_out_attr", 64'(out_attr), 64'(0));

    // Pin the model to hand-computed values.
    chk("model_area_10000", 64'(model_inv(pack(40, 20, 140, 120, 40, 120))), 64'h68D);
    chk("model_area_5000", 64'(model_inv(pack(140, 20, 190, 70, 90, 70))), 64'hD1B);
    chk("model_area_3000", 64'(model_inv(pack(20, 140, 70, 200, 20, 200))), 64'h15D8);
    chk("model_area_1", 64'(model_inv(pack(0, 0, 1, 0, 0, 1))), 64'h1000000);

    @(posedge axi_aclk);
    #1;
    axi_aresetn = 1'b1;
    @(negedge axi_aclk);
    chk("release_in_ready_before_edge", 64'(in_ready), 64'(0));
    @(negedge axi_aclk);
    chk("release_in_ready_first_edge", 64'(in_ready), 64'(1));
    @(posedge axi_aclk);
    #1;

    // Single triangle, area 10000.
    send(pack(40, 20, 140, 120, 40, 120), 56'h1111_2222_3333_44);
    drain();
    chk("tri10000_inv", 64'(last_inv), 64'h68D);
    chk("tri10000_latency", 64'(last_lat), 64'(26));
    chk("tri10000_attr", 64'(last_attr), 64'h1111_2222_3333_44);

    // Back-to-back: second is presented while the first is busy.
    send(pack(140, 20, 190, 70, 90, 70), 56'hAAAA_BBBB_CCCC_01);
    send(pack(20, 140, 70, 200, 20, 200), 56'h5555_6666_7777_02);
    drain();
    n = got_inv.size();
    chk("b2b_first_inv", 64'(got_inv[n-2]), 64'hD1B);
    chk("b2b_second_inv", 64'(got_inv[n-1]), 64'h15D8);
    chk("b2b_first_attr", 64'(got_attr[n-2]), 64'hAAAA_BBBB_CCCC_01);
    chk("b2b_second_attr", 64'(got_attr[n-1]), 64'h5555_6666_7777_02);

    // Collinear -> dropped; then unit area.
    n0 = n_pop;
    send(pack(0, 0, 10, 10, 20, 20), 56'h0);
    drain();
    chk("collinear_drop_count", 64'(drop_count), 64'(1));
    chk("collinear_no_output", 64'(n_pop), 64'(n0));
    send(pack(0, 0, 1, 0, 0, 1), 56'h00FF);
    drain();
    chk("unit_area_inv", 64'(last_inv), 64'h1000000);

    // Negative area.
    n0 = n_pop;
    send(pack(40, 20, 40, 120, 140, 120), 56'h0BAC);
    drain();
`ifdef TRI_SETUP_BACKFACE_CULL_EN
    chk("backface_drop_count", 64'(drop_count), 64'(2));
    chk("backface_no_output", 64'(n_pop), 64'(n0));
`else
    chk("negarea_inv", 64'(last_inv), 64'h68D);
    chk("negarea_drop_count", 64'(drop_count), 64'(1));
`endif

    // Output stall for 10 cycles, then a single-cycle ready pulse.
    rdy_mode  = 2;
    out_ready = 1'b0;
    send(pack(140, 20, 190, 70, 90, 70), 56'h5A5A_5A5A_5A5A_5A);
    for (n = 0; n < 100; n++) begin
      @(negedge axi_aclk);
      if (out_valid) break;
    end
    chk("stall_out_valid_seen", 64'(out_valid), 64'(1));
    n0 = n_pop;
    repeat (10) @(posedge axi_aclk);
    @(negedge axi_aclk);
    chk("stall_in_ready_low", 64'(in_ready), 64'(0));
    chk("stall_inv_hold", 64'(out_inv_area), 64'hD1B);
    @(posedge axi_aclk);
    #1;
    out_ready = 1'b1;
    @(posedge axi_aclk);
    #1;
    out_ready = 1'b0;
    repeat (5) @(posedge axi_aclk);
    #1;
    chk("stall_single_transfer", 64'(n_pop), 64'(n0 + 1));
    rdy_mode = 0;
    drain();

    // Reset during DIV (10 division steps done).
    send(pack(140, 20, 190, 70, 90, 70), 56'h0DEAD);
    repeat (11) @(posedge axi_aclk);
    #1;
    axi_aresetn = 1'b0;
    #1;
    chk("midreset_out_valid", 64'(out_valid), 64'(0));
    chk("midreset_busy", 64'(busy), 64'(0));
    chk("midreset_drop_count", 64'(drop_count), 64'(0));
    chk("midreset_out_inv", 64'(out_inv_area), 64'(0));
    chk("midreset_out_xy", 64'(out_xy), 64'(0));
    repeat (3) @(posedge axi_aclk);
    #1;
    axi_aresetn = 1'b1;
    n0 = n_pop;
    @(negedge axi_aclk);
    chk("postreset_in_ready_before_edge", 64'(in_ready), 64'(0));
    @(negedge axi_aclk);
    chk("postreset_in_ready", 64'(in_ready), 64'(1));
    @(posedge axi_aclk);
    #1;
    send(pack(20, 140, 70, 200, 20, 200), 56'h0BEEF);
    drain();
    chk("postreset_inv", 64'(last_inv), 64'h15D8);
    chk("postreset_one_output", 64'(n_pop), 64'(n0 + 1));
    chk("postreset_drop_count", 64'(drop_count), 64'(0));

    // Randomized traffic with random back-pressure.
    rdy_mode = 1;
    for (int i = 0; i < 40; i++) begin
      int x1, y1, x2, y2, x3, y3;
      x1 = $urandom_range(0, 511); y1 = $urandom_range(0, 255);
      x2 = $urandom_range(0, 511); y2 = $urandom_range(0, 255);
      x3 = $urandom_range(0, 511); y3 = $urandom_range(0, 255);
      case ($urandom % 6)
        0: begin x3 = x2; y3 = y2; end
        1: begin x1 = 0; y1 = 0; x2 = 511; y2 = 0; x3 = 0; y3 = 255; end
        default: ;
      endcase
      t = pack(x1, y1, x2, y2, x3, y3);
      send(t, {$urandom, $urandom});
    end
    drain();
    rdy_mode = 0;
    chk("final_drop_count", 64'(drop_count), 64'(model_drops));
    chk("final_queue_empty", 64'(exp_q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
